// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the switch debouncer: FSM states and default sizing.
package switch_debouncer_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic {
    STABLE  = 1'b0,  // synchronized input matches the debounced output
    PENDING = 1'b1   // synchronized input differs; counting toward acceptance
  } state_t;

  // 10 ms at 50 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  // Wide enough for DEBOUNCE_CYCLES up to 2^24-1.
  localparam int unsigned DEFAULT_CNT_W = 24;

endpackage : switch_debouncer_pkg

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchronizer, STABLE/PENDING FSM with a
// saturating-free counter, registered debounced level and a one-cycle update
// strobe (combinational, high in the cycle whose closing edge updates the level).
module debounce_channel
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_update
);

  // Counter value on which a persistent mismatch is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_level_next;
  logic             w_update;

  // Two-flop synchronizer; r_sync2 is the channel's sync value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state, counter and debounced level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_level <= w_level_next;
    end
  end

  // Next-state logic: the entry edge into PENDING does not count; the counter
  // stops at CNT_LAST, where the level is accepted, so it can never wrap.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_level_next = r_level;
    w_update     = 1'b0;
    case (r_state)
      STABLE: begin
        w_cnt_next = '0;
        if (r_sync2 != r_level) begin
          w_state_next = PENDING;
        end
      end
      PENDING: begin
        if (r_sync2 == r_level) begin
          // Bounced back before acceptance: drop the count.
          w_cnt_next   = '0;
          w_state_next = STABLE;
        end else if (r_cnt == CNT_LAST) begin
          w_level_next = r_sync2;
          w_cnt_next   = '0;
          w_state_next = STABLE;
          w_update     = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = STABLE;
      end
    endcase
  end

  assign o_level  = r_level;
  assign o_update = w_update;

endmodule : debounce_channel

// File: rtl/switch_debouncer.sv
// Three independent switch debouncers feeding the adder, plus a registered
// "any output changed" pulse.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_switch_0,
  input  logic raw_switch_1,
  input  logic raw_switch_2,
  output logic switch_0,
  output logic switch_1,
  output logic switch_2,
  output logic switch_changed
);

  logic [2:0] w_raw;
  logic [2:0] w_level;
  logic [2:0] w_update;
  logic       r_changed;

  assign w_raw = {raw_switch_2, raw_switch_1, raw_switch_0};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_chan (
        .clk     (clk),
        .reset_n (reset_n),
        .i_raw   (w_raw[gi]),
        .o_level (w_level[gi]),
        .o_update(w_update[gi])
      );
    end
  endgenerate

  // Registered OR of the update strobes: one pulse coincident with the new levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_update;
    end
  end

  assign switch_0       = w_level[0];
  assign switch_1       = w_level[1];
  assign switch_2       = w_level[2];
  assign switch_changed = r_changed;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with DEBOUNCE_CYCLES=4.
// A raw level driven at the falling edge after clock edge c reaches the first
// synchronizer flop at c+1 and the sync flop at c+2; the output then follows at
// (c+2)+1+N = c+N+3 = c+7, with switch_changed high in the cycle after that edge.
module tb_switch_debouncer;

  localparam int unsigned N   = 4;
  localparam int unsigned LAT = N + 3;

  typedef struct {
    logic [2:0]  sw;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic raw_switch_0, raw_switch_1, raw_switch_2;
  logic switch_0, switch_1, switch_2, switch_changed;
  logic [2:0] w_sw;

  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  switch_debouncer #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .raw_switch_0  (raw_switch_0),
    .raw_switch_1  (raw_switch_1),
    .raw_switch_2  (raw_switch_2),
    .switch_0      (switch_0),
    .switch_1      (switch_1),
    .switch_2      (switch_2),
    .switch_changed(switch_changed)
  );

  assign w_sw = {switch_2, switch_1, switch_0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input logic [2:0] sw, input int unsigned at_cyc);
    exp_t e;
    e.sw  = sw;
    e.cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, req, cyc);
    end else begin
      $display("check %s: %b ok (cyc %0d)", name, act, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every switch_changed pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b0) begin
      if (switch_changed !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL reset_pulse: switch_changed=%b expected 0 in reset", switch_changed);
      end
    end else if (switch_changed === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got pulse sw=%b at cyc %0d expected none", w_sw, cyc);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (w_sw !== e.sw) begin
          failures++;
          $display("FAIL pulse_value: got %b expected %b (cyc %0d)", w_sw, e.sw, cyc);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL pulse_time: got cyc %0d expected cyc %0d", cyc, e.cyc);
        end
        $display("pulse cyc=%0d sw=%b expected cyc=%0d sw=%b", cyc, w_sw, e.cyc, e.sw);
      end
    end
  end

  initial begin
    int unsigned c;
    int unsigned r;
    reset_n      = 1'b0;
    raw_switch_0 = 1'b0;
    raw_switch_1 = 1'b0;
    raw_switch_2 = 1'b0;
    wait_n(3);
    check3("reset_outputs", w_sw, 3'b000);
    check3("reset_changed", {2'b00, switch_changed}, 3'b000);
    reset_n = 1'b1;
    wait_n(3);

    // Clean press and release on channel 0.
    c = cyc; raw_switch_0 = 1'b1; push_exp(3'b001, c + LAT);
    wait_n(10);
    check3("press0_level", w_sw, 3'b001);
    c = cyc; raw_switch_0 = 1'b0; push_exp(3'b000, c + LAT);
    wait_n(10);

    // Bounce on channel 1: high 3, low 1, high; the count restarts from the last rise.
    raw_switch_1 = 1'b1;
    wait_n(3);
    raw_switch_1 = 1'b0;
    wait_n(1);
    c = cyc; raw_switch_1 = 1'b1; push_exp(3'b010, c + LAT);
    wait_n(LAT - 1);
    check3("bounce_not_yet", w_sw, 3'b000);
    wait_n(6);
    c = cyc; raw_switch_1 = 1'b0; push_exp(3'b000, c + LAT);
    wait_n(10);

    // Glitch of 2 cycles on channel 2: never accepted.
    raw_switch_2 = 1'b1;
    wait_n(2);
    raw_switch_2 = 1'b0;
    wait_n(12);
    check3("glitch_ignored", w_sw, 3'b000);

    // Staggered changes complete independently.
    c = cyc; raw_switch_0 = 1'b1; push_exp(3'b001, c + LAT);
    wait_n(2);
    raw_switch_2 = 1'b1; push_exp(3'b101, c + 2 + LAT);
    wait_n(12);
    c = cyc; raw_switch_0 = 1'b0; raw_switch_2 = 1'b0; push_exp(3'b000, c + LAT);
    wait_n(10);

    // Simultaneous press on all channels: one pulse, adder sees 3'b111.
    c = cyc;
    raw_switch_0 = 1'b1; raw_switch_1 = 1'b1; raw_switch_2 = 1'b1;
    push_exp(3'b111, c + LAT);
    wait_n(12);
    check3("all_pressed", w_sw, 3'b111);

    // Asynchronous reset assertion mid-cycle; switches held high through reset.
    #2 reset_n = 1'b0;
    #1 check3("async_reset_outputs", w_sw, 3'b000);
    wait_n(2);
    r = cyc; reset_n = 1'b1; push_exp(3'b111, r + LAT);
    wait_n(LAT - 1);
    check3("held_not_yet", w_sw, 3'b000);
    wait_n(6);
    c = cyc;
    raw_switch_0 = 1'b0; raw_switch_1 = 1'b0; raw_switch_2 = 1'b0;
    push_exp(3'b000, c + LAT);
    wait_n(10);

    // Reset while channel 0 is PENDING with count 2: count discarded.
    c = cyc; raw_switch_0 = 1'b1;
    wait_n(5);
    reset_n = 1'b0;
    #1 check3("midcount_reset", {switch_changed, w_sw[1:0]}, 3'b000);
    wait_n(1);
    r = cyc; reset_n = 1'b1; push_exp(3'b001, r + LAT);
    wait_n(LAT - 1);
    check3("midcount_restart", w_sw, 3'b000);
    wait_n(6);
    c = cyc; raw_switch_0 = 1'b0; push_exp(3'b000, c + LAT);
    wait_n(12);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: got %0d unconsumed expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_switch_debouncer
